aes256_key_sched_ctrl: RTL and testbench

Iterative AES-256 key-schedule controller. It accepts a 256-bit cipher key over a valid/ready handshake and computes the 15 round keys, one 256-bit key-schedule step per cycle, through a single shared step unit. The results are held in an internal key store. The cipher datapath reads round keys by index, so the core no longer needs seven chained step instances.

---
 rtl/aes_pkg.sv | 63 ++++++
 rtl/aes256_key_step.sv | 28 ++
 rtl/aes256_key_sched_ctrl.sv | 89 ++++++++
 tb/tb_aes256_key_sched_ctrl.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// Shared AES-256 key-schedule types, constants and byte-level helpers.
// Bit numbering: vector bit 255 carries bit 0 (MSB of byte 0) of the key.
package aes_pkg;

    localparam int unsigned NUM_ROUNDS = 14;
    localparam int unsigned STEPS      = (NUM_ROUNDS + 2) / 2 - 1;
    localparam int unsigned NUM_SLOTS  = STEPS + 1;

    typedef logic [127:0] round_key_t;
    typedef logic [255:0] sched_blk_t;

    typedef enum logic [1:0] {
        IDLE,
        EXPAND,
        DONE
    } state_t;

    localparam logic [2047:0] SBOX_TABLE = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    // Entry x sits at bits [(255-x)*8 +: 8]; (255-x)*8 is just {~x, 3'b000}.
    function automatic logic [7:0] sbox(input logic [7:0] x);
        return SBOX_TABLE[{~x, 3'b000} +: 8];
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] r);
        case (r)
            4'd1:    return 8'h01;
            4'd2:    return 8'h02;
            4'd3:    return 8'h04;
            4'd4:    return 8'h08;
            4'd5:    return 8'h10;
            4'd6:    return 8'h20;
            4'd7:    return 8'h40;
            default: return 8'h00;
        endcase
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

    function automatic logic [31:0] rot_word(input logic [31:0] w);
        return {w[23:0], w[31:24]};
    endfunction

endpackage

// File: rtl/aes256_key_step.sv
// One 256-bit AES-256 key-expansion step (eight words) for round index r.
module aes256_key_step
    import aes_pkg::*;
(
    input  logic [255:0] k,
    input  logic [3:0]   r,
    output logic [255:0] result
);

    logic [31:0] w [8];
    logic [31:0] n [8];

    always_comb begin
        for (int unsigned i = 0; i < 8; i++) begin
            w[i] = k[255 - 32*i -: 32];
        end
        n[0] = w[0] ^ sub_word(rot_word(w[7])) ^ {rcon(r), 24'h000000};
        for (int unsigned i = 1; i < 4; i++) begin
            n[i] = w[i] ^ n[i-1];
        end
        n[4] = w[4] ^ sub_word(n[3]);
        for (int unsigned i = 5; i < 8; i++) begin
            n[i] = w[i] ^ n[i-1];
        end
        result = {n[0], n[1], n[2], n[3], n[4], n[5], n[6], n[7]};
    end

endmodule

// File: rtl/aes256_key_sched_ctrl.sv
// Iterative AES-256 key schedule: one shared step unit, 8-slot round-key store,
// combinational round-key read port indexed by rk_idx_i.
module aes256_key_sched_ctrl
    import aes_pkg::*;
(
    input  logic         clk_i,
    input  logic         reset_n_i,
    input  logic [255:0] key_i,
    input  logic         key_v_i,
    output logic         key_ready_o,
    input  logic [3:0]   rk_idx_i,
    output logic [127:0] rk_o,
    output logic         keys_v_o,
    output logic         busy_o
);

    state_t     state;
    sched_blk_t work;
    logic [3:0] cnt;
    sched_blk_t store [NUM_SLOTS];
    sched_blk_t step_res;
    logic       last_step;

    aes256_key_step u_step (
        .k      (work),
        .r      (cnt),
        .result (step_res)
    );

    assign last_step = (cnt == 4'(STEPS));

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state       <= IDLE;
            key_ready_o <= 1'b1;
            keys_v_o    <= 1'b0;
            busy_o      <= 1'b0;
            cnt         <= '0;
            work        <= '0;
            for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
                store[i] <= '0;
            end
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (key_v_i && key_ready_o) begin
                        store[0]    <= key_i;
                        work        <= key_i;
                        cnt         <= 4'd1;
                        state       <= EXPAND;
                        key_ready_o <= 1'b0;
                        keys_v_o    <= 1'b0;
                        busy_o      <= 1'b1;
                    end
                end
                EXPAND: begin
                    // The final slot only holds round key 14; its upper half stays zero,
                    // which also makes index 15 read back as zero.
                    store[cnt[2:0]] <= last_step ? {step_res[255:128], 128'h0} : step_res;
                    work            <= step_res;
                    if (last_step) begin
                        cnt         <= '0;
                        state       <= DONE;
                        key_ready_o <= 1'b1;
                        keys_v_o    <= 1'b1;
                        busy_o      <= 1'b0;
                    end else begin
                        cnt <= cnt + 4'd1;
                    end
                end
                default: begin
                    state       <= IDLE;
                    key_ready_o <= 1'b1;
                    keys_v_o    <= 1'b0;
                    busy_o      <= 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        rk_o = '0;
        if (rk_idx_i <= 4'(NUM_ROUNDS)) begin
            rk_o = rk_idx_i[0] ? store[rk_idx_i[3:1]][127:0]
                               : store[rk_idx_i[3:1]][255:128];
        end
    end

endmodule

// File: tb/tb_aes256_key_sched_ctrl.sv
// Directed bench for aes256_key_sched_ctrl: FIPS-197 vectors, handshake timing,
// async reset and back-to-back expansions against a word-wise reference expansion.
module tb_aes256_key_sched_ctrl;
    import aes_pkg::*;

    logic         clk_i = 1'b0;
    logic         reset_n_i;
    logic [255:0] key_i;
    logic         key_v_i;
    logic         key_ready_o;
    logic [3:0]   rk_idx_i;
    logic [127:0] rk_o;
    logic         keys_v_o;
    logic         busy_o;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk_i = ~clk_i;

    aes256_key_sched_ctrl dut (
        .clk_i       (clk_i),
        .reset_n_i   (reset_n_i),
        .key_i       (key_i),
        .key_v_i     (key_v_i),
        .key_ready_o (key_ready_o),
        .rk_idx_i    (rk_idx_i),
        .rk_o        (rk_o),
        .keys_v_o    (keys_v_o),
        .busy_o      (busy_o)
    );

    localparam logic [255:0] KEY_C3 =
        256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    localparam logic [255:0] KEY_A3 =
        256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;

    typedef struct {
        logic [255:0] key;
        logic [3:0]   idx;
        logic [127:0] exp;
    } vec_t;

    vec_t vt[$];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    function automatic logic [31:0] ref_subw(input logic [31:0] w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

    // Classic FIPS-197 word-by-word expansion to 60 words.
    function automatic logic [127:0] model_rk(input logic [255:0] key, input int idx);
        logic [31:0] w [60];
        logic [31:0] t;
        logic [7:0]  rc;
        for (int i = 0; i < 8; i++) w[i] = key[255 - 32*i -: 32];
        rc = 8'h01;
        for (int i = 8; i < 60; i++) begin
            t = w[i-1];
            if (i % 8 == 0) begin
                t  = ref_subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
                rc = {rc[6:0], 1'b0} ^ (rc[7] ? 8'h1b : 8'h00);
            end else if (i % 8 == 4) begin
                t = ref_subw(t);
            end
            w[i] = w[i-8] ^ t;
        end
        if (idx > 14) return '0;
        return {w[4*idx], w[4*idx+1], w[4*idx+2], w[4*idx+3]};
    endfunction

    function automatic logic [255:0] rand_key();
        logic [255:0] k = '0;
        for (int i = 0; i < 8; i++) k = {k[223:0], 32'($urandom())};
        return k;
    endfunction

    task automatic send_key(input logic [255:0] k);
        key_i   = k;
        key_v_i = 1'b1;
        tick();
        key_v_i = 1'b0;
    endtask

    // Called right after the handshake edge: expects exactly 7 busy cycles then DONE.
    task automatic expand_check(input string name);
        for (int c = 0; c < 7; c++) begin
            chk($sformatf("%s_busy%0d", name, c), {busy_o, keys_v_o, key_ready_o}, 3'b100);
            tick();
        end
        chk($sformatf("%s_done", name), {busy_o, keys_v_o, key_ready_o}, 3'b011);
    endtask

    task automatic wait_keys(input string name);
        int cyc = 0;
        while (!keys_v_o && cyc < 20) begin
            tick();
            cyc++;
        end
        chk($sformatf("%s_wait", name), keys_v_o, 1'b1);
    endtask

    task automatic read_all(input string name, input logic [255:0] k);
        for (int i = 0; i < 16; i++) begin
            rk_idx_i = 4'(i);
            #1;
            chk($sformatf("%s_rk%0d", name, i), rk_o, model_rk(k, i));
        end
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [255:0] cur;
        logic [255:0] ka;
        int           highs;
        int           first_high;

        vt.push_back('{KEY_C3, 4'd0,  128'h000102030405060708090a0b0c0d0e0f});
        vt.push_back('{KEY_C3, 4'd1,  128'h101112131415161718191a1b1c1d1e1f});
        vt.push_back('{KEY_C3, 4'd2,  128'ha573c29fa176c498a97fce93a572c09c});
        vt.push_back('{KEY_C3, 4'd3,  128'h1651a8cd0244beda1a5da4c10640bade});
        vt.push_back('{KEY_C3, 4'd4,  128'hae87dff00ff11b68a68ed5fb03fc1567});
        vt.push_back('{KEY_C3, 4'd5,  128'h6de1f1486fa54f9275f8eb5373b8518d});
        vt.push_back('{KEY_C3, 4'd6,  128'hc656827fc9a799176f294cec6cd5598b});
        vt.push_back('{KEY_C3, 4'd7,  128'h3de23a75524775e727bf9eb45407cf39});
        vt.push_back('{KEY_C3, 4'd8,  128'h0bdc905fc27b0948ad5245a4c1871c2f});
        vt.push_back('{KEY_C3, 4'd9,  128'h45f5a66017b2d387300d4d33640a820a});
        vt.push_back('{KEY_C3, 4'd10, 128'h7ccff71cbeb4fe5413e6bbf0d261a7df});
        vt.push_back('{KEY_C3, 4'd11, 128'hf01afafee7a82979d7a5644ab3afe640});
        vt.push_back('{KEY_C3, 4'd12, 128'h2541fe719bf500258813bbd55a721c0a});
        vt.push_back('{KEY_C3, 4'd13, 128'h4e5a6699a9f24fe07e572baacdf8cdea});
        vt.push_back('{KEY_C3, 4'd14, 128'h24fc79ccbf0979e9371ac23c6d68de36});
        vt.push_back('{KEY_C3, 4'd15, 128'h0});
        vt.push_back('{KEY_A3, 4'd0,  128'h603deb1015ca71be2b73aef0857d7781});
        vt.push_back('{KEY_A3, 4'd1,  128'h1f352c073b6108d72d9810a30914dff4});
        vt.push_back('{KEY_A3, 4'd2,  128'h9ba354118e6925afa51a8b5f2067fcde});
        vt.push_back('{KEY_A3, 4'd3,  128'ha8b09c1a93d194cdbe49846eb75d5b9a});
        vt.push_back('{KEY_A3, 4'd15, 128'h0});

        reset_n_i = 1'b0;
        key_v_i   = 1'b0;
        key_i     = '0;
        rk_idx_i  = 4'd0;
        #12;
        chk("reset_flags", {busy_o, keys_v_o, key_ready_o}, 3'b001);
        chk("reset_rk0", rk_o, 128'h0);
        reset_n_i = 1'b1;
        tick();
        chk("idle_flags", {busy_o, keys_v_o, key_ready_o}, 3'b001);

        cur = '0;
        for (int i = 0; i < vt.size(); i++) begin
            if (i == 0 || vt[i].key !== cur) begin
                send_key(vt[i].key);
                expand_check($sformatf("vec%0d_load", i));
                cur = vt[i].key;
            end
            rk_idx_i = vt[i].idx;
            #1;
            chk($sformatf("vec%0d_idx%0d", i, vt[i].idx), rk_o, vt[i].exp);
        end
        read_all("a3", KEY_A3);

        // A second key offered while expanding must be ignored.
        ka = rand_key();
        send_key(ka);
        tick();
        tick();
        key_i   = ~ka;
        key_v_i = 1'b1;
        #1;
        chk("midexp_ready", key_ready_o, 1'b0);
        tick();
        tick();
        key_v_i = 1'b0;
        wait_keys("midexp");
        read_all("midexp", ka);

        for (int n = 0; n < 3; n++) begin
            ka = rand_key();
            send_key(ka);
            expand_check($sformatf("b2b%0d", n));
            read_all($sformatf("b2b%0d", n), ka);
        end

        // Asynchronous reset between edges at step 4.
        send_key(rand_key());
        tick();
        tick();
        tick();
        #2;
        reset_n_i = 1'b0;
        #1;
        chk("areset_flags", {busy_o, keys_v_o, key_ready_o}, 3'b001);
        chk("areset_rk0", rk_o, 128'h0);
        #2;
        reset_n_i = 1'b1;
        tick();
        chk("areset_hold", {busy_o, keys_v_o, key_ready_o}, 3'b001);
        ka = rand_key();
        send_key(ka);
        expand_check("after_rst");
        read_all("after_rst", ka);

        // key_v_i held high: restart every 8 cycles, keys_v_o high one cycle per period.
        ka = rand_key();
        key_i      = ka;
        key_v_i    = 1'b1;
        highs      = 0;
        first_high = -1;
        for (int c = 1; c <= 32; c++) begin
            tick();
            if (keys_v_o) begin
                highs++;
                if (first_high < 0) first_high = c;
                chk($sformatf("held_period_c%0d", c), 32'(c % 8), 32'd0);
            end
        end
        key_v_i = 1'b0;
        chk("held_highs", 32'(highs), 32'd4);
        chk("held_first", 32'(first_high), 32'd8);
        chk("held_state", {busy_o, keys_v_o, key_ready_o}, 3'b011);
        read_all("held", ka);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
